// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RISC-V instruction encoder.
package instr_enc_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Canonical NOP (addi x0, x0, 0) emitted in place of unknown opcodes
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_SB,
    FMT_U,
    FMT_R,
    FMT_ILL
  } fmt_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_OK       = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_MISALIGN = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Map an opcode to its encoding format
  function automatic fmt_e fmt_of(input logic [OPC_W-1:0] op);
    fmt_e f;
    case (op)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_STORE:                      f = FMT_S;
      OPC_BRANCH:                     f = FMT_SB;
      OPC_LUI:                        f = FMT_U;
      OPC_OP:                         f = FMT_R;
      default:                        f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packing and immediate range checking for one request.
module imm_pack
  import instr_enc_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [F7_W-1:0]  i_funct7,
  input  logic [REG_W-1:0] i_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [XLEN-1:0]  i_imm,
  output logic [ILEN-1:0]  o_instr_c,
  output err_e             o_err_c
);

  fmt_e w_fmt;
  logic w_sext11;
  logic w_sext12;
  logic w_sext31;
  logic w_lo12_zero;
  logic w_range_ok;

  // Pack fields per format, then pick the highest-priority error
  always_comb begin
    w_fmt       = fmt_of(i_opcode);
    w_sext11    = (&i_imm[XLEN-1:11]) | ~(|i_imm[XLEN-1:11]);
    w_sext12    = (&i_imm[XLEN-1:12]) | ~(|i_imm[XLEN-1:12]);
    w_sext31    = (&i_imm[XLEN-1:31]) | ~(|i_imm[XLEN-1:31]);
    w_lo12_zero = ~(|i_imm[11:0]);
    w_range_ok  = 1'b1;
    o_instr_c   = NOP_INSTR;
    o_err_c     = ERR_OK;

    case (w_fmt)
      FMT_I: begin
        o_instr_c  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_range_ok = w_sext11;
      end
      FMT_S: begin
        o_instr_c  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_range_ok = w_sext11;
      end
      FMT_SB: begin
        o_instr_c  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], i_opcode};
        w_range_ok = w_sext12;
      end
      FMT_U: begin
        o_instr_c  = {i_imm[31:12], i_rd, i_opcode};
        w_range_ok = w_sext31 & w_lo12_zero;
      end
      FMT_R: begin
        o_instr_c  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      default: begin
        o_instr_c  = NOP_INSTR;
      end
    endcase

    if (w_fmt == FMT_ILL) begin
      o_err_c = ERR_ILLEGAL;
    end else if (!w_range_ok) begin
      o_err_c = ERR_RANGE;
    end else if ((w_fmt == FMT_SB) && i_imm[0]) begin
      o_err_c = ERR_MISALIGN;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: program FSM, one-deep output register,
// address counter and saturating error counter around imm_pack.
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_addr,
  output logic [ERR_W-1:0] out_err,
  output logic             done,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            r_state;
  logic              r_out_valid;
  logic [ILEN-1:0]   r_out_instr;
  logic [XLEN-1:0]   r_out_addr;
  err_e              r_out_err;
  logic              r_done;
  logic [CNT_W-1:0]  r_err_count;
  logic [XLEN-1:0]   r_next_addr;

  logic [ILEN-1:0]   w_instr;
  err_e              w_err;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_handoff;

  imm_pack u_imm_pack (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .i_rd     (rd),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_imm    (imm),
    .o_instr_c(w_instr),
    .o_err_c  (w_err)
  );

  // Accept only while running and the output slot is free or being drained
  assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_handoff  = r_out_valid && out_ready;

  // Program FSM, output register, address counter and error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_out_err   <= ERR_OK;
      r_done      <= 1'b0;
      r_err_count <= '0;
      r_next_addr <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_handoff) begin
        r_out_valid <= 1'b0;
        if ((r_out_err != ERR_OK) && (r_err_count != CNT_MAX)) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end

      // A same-cycle accept overrides the clear above, keeping full throughput
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
        r_out_addr  <= r_next_addr;
        r_next_addr <= r_next_addr + XLEN'(4);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_next_addr <= base_addr;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept && in_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_handoff) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign done      = r_done;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every hand-off.
module tb_instr_encoder;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BAD    = 7'h7F;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic [1:0]  err;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [63:0] imm = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic [1:0]  out_err;
  logic        done;
  logic [15:0] err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  logic [63:0] model_addr = '0;
  logic [15:0] model_cnt = '0;

  instr_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr (out_addr),
    .out_err  (out_err),
    .done     (done),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] a, input bit load);
    start     = 1'b1;
    base_addr = a;
    tick();
    start = 1'b0;
    if (load) model_addr = a;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [63:0] im, input logic lst,
                      input logic [31:0] e_instr, input logic [1:0] e_err);
    bit ok;
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_last  = lst;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sb_q.push_back('{e_instr, model_addr, e_err, lst});
      model_addr = model_addr + 64'd4;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words pending, required 0", sb_q.size());
    end
    tick();
    tick();
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each hand-off
  initial begin
    bit          prev_accept = 1'b0;
    bit          prev_stall  = 1'b0;
    bit          prev_last   = 1'b0;
    bit          last_now;
    logic [31:0] p_instr = '0;
    logic [63:0] p_addr  = '0;
    logic [1:0]  p_err   = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_accept = 1'b0;
        prev_stall  = 1'b0;
        prev_last   = 1'b0;
      end else begin
        check("done", 64'(done), 64'(prev_last));
        if (prev_accept) check("valid_after_accept", 64'(out_valid), 64'd1);
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_instr", 64'(out_instr), 64'(p_instr));
          check("hold_addr", out_addr, p_addr);
          check("hold_err", 64'(out_err), 64'(p_err));
        end
        if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
        last_now = 1'b0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got out_valid=1 addr=0x%0h, required no output", out_addr);
          end else begin
            e = sb_q.pop_front();
            check("instr", 64'(out_instr), 64'(e.instr));
            check("addr", out_addr, e.addr);
            check("err", 64'(out_err), 64'(e.err));
            check("err_count", 64'(err_count), 64'(model_cnt));
            if (e.err != 2'b00 && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            last_now = e.last;
          end
        end
        prev_accept = in_valid && in_ready;
        prev_stall  = out_valid && !out_ready;
        prev_last   = last_now;
        p_instr     = out_instr;
        p_addr      = out_addr;
        p_err       = out_err;
      end
    end
  end

  initial begin
    // Reset values
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Program 1: every format, range and error boundary
    do_start(64'h400, 1'b1);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFF00093, 2'b00);
    send(STORE,  3'd3, 7'd0, 5'd0, 5'd3, 5'd2, 64'd8,                   1'b0, 32'h0021B423, 2'b00);
    do_start(64'h9000, 1'b0);
    send(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFE208EE3, 2'b00);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd2048,                1'b0, 32'h80000093, 2'b01);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 32'h80000093, 2'b00);
    send(STORE,  3'd3, 7'd0, 5'd0, 5'd3, 5'd2, 64'h0000_0001_0000_0000, 1'b0, 32'h0021B023, 2'b01);
    send(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd3,                   1'b0, 32'h00208163, 2'b11);
    send(BAD,    3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 64'd5,                   1'b0, 32'h00000013, 2'b10);
    send(LOAD,   3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 64'd4,                   1'b0, 32'h0040A283, 2'b00);
    send(JALR,   3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 64'd0,                   1'b0, 32'h00008067, 2'b00);
    send(LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000,           1'b0, 32'h123452B7, 2'b00);
    send(LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 32'h800002B7, 2'b00);
    send(LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h123,                 1'b0, 32'h000002B7, 2'b01);
    send(OP,     3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'hDEAD,               1'b0, 32'h002081B3, 2'b00);
    send(OP,     3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'd0,                  1'b1, 32'h402081B3, 2'b00);
    drain();
    check("err_count_prog1", 64'(err_count), 64'd5);

    // Program 2: streaming with back-pressure and address wrap
    do_start(64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    fork
      begin
        send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd1, 1'b0, 32'h00100093, 2'b00);
        send(OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 64'd2, 1'b0, 32'h00200113, 2'b00);
        send(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 64'd3, 1'b0, 32'h00300193, 2'b00);
        send(OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 64'd4, 1'b0, 32'h00400213, 2'b00);
        send(OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500293, 2'b00);
      end
      begin
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("err_count_prog2", 64'(err_count), 64'd5);

    // Reset mid-RUN with a word held in the output register
    do_start(64'h100, 1'b1);
    out_ready = 1'b0;
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd1, 1'b0, 32'h00100093, 2'b00);
    tick();
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_instr", 64'(out_instr), 64'd0);
    sb_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    opcode    = OP_IMM;
    in_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("post_rst_no_output", 64'(out_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd0);
    end
    tick();
    in_valid = 1'b0;

    // Program 4: fresh start after reset, misaligned branch counted once
    do_start(64'h200, 1'b1);
    send(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd3, 1'b1, 32'h00208163, 2'b11);
    drain();
    check("err_count_prog4", 64'(err_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins a program and loads base_addr.
REQ-004 SHALL have port base_addr, input, 64 bits: byte address of the first emitted word.
REQ-005 SHALL have in_valid (input, 1) and in_ready (output, 1) as the request handshake.
REQ-006 SHALL have the request fields: opcode[7], funct3[3], funct7[7], rd[5], rs1[5], rs2[5], imm[64] and in_last[1], all inputs.
REQ-007 SHALL have out_valid (output, 1) and out_ready (input, 1) as the result handshake.
REQ-008 SHALL have the result fields: out_instr[32], out_addr[64] and out_err[2], all outputs.
REQ-009 SHALL have done (output, 1): one-cycle pulse after the last word is handed off.
REQ-010 SHALL have err_count (output, 16): saturating count of results with out_err != 0.

Function
REQ-011 SHALL use three FSM states: IDLE, RUN and DRAIN.
- IDLE to RUN on start.
- RUN to DRAIN when a beat with in_last=1 is accepted.
- DRAIN to IDLE when that beat is handed off; done=1 in that cycle.
REQ-012 SHALL drive in_ready=1 only in RUN, and only when (!out_valid || out_ready).
REQ-013 SHALL accept a beat on in_valid && in_ready; the registered result appears with out_valid=1 on the next cycle (latency 1).
REQ-014 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-015 SHALL allow an accept and a hand-off in the same cycle, giving full throughput of 1 word per cycle.
REQ-016 SHALL drive out_addr = base_addr for the first word, then +4 per accepted beat, wrapping modulo 2^64.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL encode by opcode as follows:
- I, for 0010011 / 0000011 / 1100111: {imm[11:0],rs1,funct3,rd,opcode}.
- S, for 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
- SB, for 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
- U, for 0110111: {imm[31:12],rd,opcode}.
- R, for 0110011: {funct7,rs2,rs1,funct3,rd,opcode}; imm is ignored.
REQ-019 SHALL apply these range rules:
- I and S: imm[63:11] all equal.
- SB: imm[63:12] all equal.
- U: imm[63:31] all equal and imm[11:0]==0.
REQ-020 SHALL set out_err as follows, highest priority first:
- 10: opcode not listed; out_instr=32'h00000013.
- 01: range rule violated; fields are truncated as in REQ-018.
- 11: SB with imm[0]=1; imm[0] is dropped.
- 00: otherwise.
REQ-021 SHALL increment err_count on hand-off of a result with out_err != 0, and hold it at 16'hFFFF once it reaches that value.

Reset
REQ-022 SHALL, on reset assertion and regardless of clk, force:
- state=IDLE
- out_valid=0, in_ready=0, done=0
- out_instr=0, out_addr=0, out_err=0
- err_count=0
REQ-023 SHALL discard any in-flight word when reset occurs mid-RUN, and emit nothing until the next start.

Structure
REQ-024 SHALL define the following in package instr_enc_pkg:
- opcode constants
- fmt enum: I, S, SB, U, R, ILL
- err_code enum: OK=00, RANGE=01, ILLEGAL=10, MISALIGN=11
- FSM state enum
- NOP constant 32'h00000013
REQ-025 SHALL place the combinational encoding and range check in a sub-module imm_pack; instr_encoder holds the FSM, the handshake register, the address counter and err_count.

Verification
REQ-026 SHALL test ADDI, I format: base_addr=0x400, imm=64'hFFFF_FFFF_FFFF_FFFF, rd=1, rs1=0, funct3=0 -> out_instr=0xFFF00093, out_err=00, out_addr=0x400.
REQ-027 SHALL test SD, S format: rs1=3, rs2=2, funct3=011, imm=8 -> 0x0021B423, out_addr=0x404.
REQ-028 SHALL test BEQ, SB format: rs1=1, rs2=2, funct3=000, imm=-4 -> 0xFE208EE3; the same beat with imm=3 -> out_err=11.
REQ-029 SHALL test ADDI with imm=2048 and rd=1 -> out_instr=0x80000093, out_err=01, err_count=1; opcode 7'h7F -> 0x00000013, out_err=10.
REQ-030 SHALL test back-pressure: out_ready=0 for 3 cycles with a streaming source -> in_ready=0, outputs stable; after release one word is handed off per cycle, and done pulses one cycle after the in_last beat is handed off.
REQ-031 SHALL test reset asserted mid-RUN with out_valid=1 -> out_valid=0 and err_count=0 immediately, with no output until start.
